multimode_counter: RTL and testbench
====================================

# multimode_counter

Parametrised successor to the lab's fixed 4-bit ripple, synchronous and Johnson down counters. A single WIDTH-bit register steps through one of four code sequences (binary, Johnson, Gray, one-hot ring), selected at run time, in either direction. It supports enable, synchronous load with legality check, and wrap or saturate at the terminal state. It sits under the lab top level, clocked from the divided clock and driving the LEDs.

## Interface
- WIDTH, 4, counter width in bits; legal range 2..32.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- en  in  1  step enable.
- mode  in  2  sequence select: 00 binary, 01 Johnson, 10 Gray, 11 ring.
- dir  in  1  0 = down, 1 = up.
- sat  in  1  1 = hold at terminal state, 0 = wrap.
- load  in  1  synchronous load request.
- load_val  in  WIDTH  value to load.
- count  out  WIDTH  registered counter state.
- tc  out  1  combinational: count equals the terminal state for the current mode/dir.
- wrap  out  1  registered one-cycle pulse, cycle after a wrap step.
- err  out  1  registered one-cycle pulse, cycle after a rejected load.

## Operation
- Origin O per mode:
  - binary 0.
  - Johnson 0.
  - Gray 0.
  - ring 0…01.
- Down terminal = O. Up terminal = the up-sequence predecessor of O:
  - binary all-ones.
  - Johnson 10…0.
  - Gray 10…0.
  - ring 10…0.
- Binary sequence: count ± 1 mod 2^WIDTH.
- Gray sequence: count = gray(i); next = gray(i ± 1 mod 2^WIDTH), where i is recovered from count by a gray-to-binary conversion.
- Johnson sequence (2·WIDTH states):
  - Up: shift left, new LSB = ~MSB.
  - Down: shift right, new MSB = ~LSB.
- Ring sequence:
  - Up: rotate left.
  - Down: rotate right.
- Legality:
  - Binary and Gray: every value is legal.
  - Johnson: legal iff at most one index i in 0..WIDTH-2 has bit[i] ≠ bit[i+1].
  - Ring: legal iff exactly one bit is set.
- Internal prev_mode register holds the mode sampled at the last edge.
- Per-edge priority, highest first:
  1. rst = 0: count ← O(mode), prev_mode ← mode, wrap ← 0, err ← 0.
  2. load = 1:
     - legal load_val: count ← load_val, err ← 0.
     - illegal load_val: count ← O(mode), err ← 1.
  3. mode ≠ prev_mode: count ← O(mode).
  4. en = 1 at the terminal state:
     - sat = 1: count holds.
     - sat = 0: count takes the next state (the wrap), wrap ← 1.
  5. en = 1 otherwise:
     - count is an illegal Johnson/ring pattern: count ← O(mode).
     - count is legal: count ← next state.
  6. en = 0: count holds.
- wrap and err are 0 on every edge where their set condition is absent.
- prev_mode ← mode on every edge.
- dir, sat and mode are sampled every edge, so direction can reverse mid-sequence with no dead cycle.

## Timing
- All state updates on the rising edge of clk; no combinational path from inputs to count.
- Reset values (after an edge with rst = 0):
  - count = O(mode).
  - wrap = 0.
  - err = 0.
  - tc = 1 if dir = 0 (count is at O), else 0 for all legal WIDTH.
- rst changing between edges has no effect until the next edge.
- Step latency: count changes one edge after en is sampled high.
- Load latency: one edge. err is valid in the same cycle the rejected load takes effect.
- wrap rises in the cycle after the count leaves the terminal state.
- tc is combinational from count/mode/dir. After a mode or dir change it reflects the new selection against the current count within the same cycle.
- Load has priority over mode change. Loading a value legal for the new mode on the edge where mode changes keeps the loaded value.

## Test plan
- **Binary down.** WIDTH = 4, reset, then mode = 00, dir = 0, en = 1 for 18 cycles -> count 0, 15, 14, …, 1, 0, 15; tc = 1 whenever count = 0; wrap pulses once per 16 steps, in the cycle showing 15.
- **Johnson down.** mode = 01, dir = 0 -> count 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000, 1000; period 8; wrap pulses at each second 1000.
- **Gray up, saturating.** mode = 10, dir = 1, sat = 1 -> count 0, 1, 3, 2, 6, 7, 5, 4, C, D, F, E, A, B, 9, 8, then holds at 8 with tc = 1 and wrap never asserted. Then set dir = 0 -> next count 9.
- **Ring load check.** mode = 11, dir = 0:
  - load_val = 0110 -> count 0001, err = 1 for one cycle.
  - load_val = 0100 -> err = 0, then count 0010, 0001, 1000 with a wrap pulse after 1000.
- **Mode switch mid-count.** Binary at count 5, change mode to 01 with en = 1 -> count 0000 next edge, then 1000.
- **Same-edge priority.** With load = 1 and en = 1, rst = 0 wins: count = origin, err = 0. With rst = 1, load wins over en: count = load_val, no step that edge.

Source files
------------

// File: rtl/multimode_counter.sv
// Multi-sequence WIDTH-bit counter: binary, Johnson, Gray or one-hot ring,
// up or down, with enable, checked synchronous load and wrap/saturate control.
module multimode_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             err
);

    localparam logic [1:0] MODE_BIN  = 2'b00;
    localparam logic [1:0] MODE_JOHN = 2'b01;
    localparam logic [1:0] MODE_GRAY = 2'b10;
    localparam logic [1:0] MODE_RING = 2'b11;

    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] origin(input logic [1:0] m);
        return (m == MODE_RING) ? WIDTH'(1) : '0;
    endfunction

    // Down terminal is the origin; up terminal is the origin's up-predecessor.
    function automatic logic [WIDTH-1:0] terminal(input logic [1:0] m, input logic d);
        logic [WIDTH-1:0] t;
        if (!d)
            t = origin(m);
        else if (m == MODE_BIN)
            t = '1;
        else
            t = MSB_ONLY;
        return t;
    endfunction

    function automatic logic is_legal(input logic [1:0] m, input logic [WIDTH-1:0] v);
        logic ok;
        case (m)
            MODE_JOHN: ok = ($countones(v[WIDTH-2:0] ^ v[WIDTH-1:1]) <= 1);
            MODE_RING: ok = ($countones(v) == 1);
            default:   ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [WIDTH-1:0] gray_step(input logic [WIDTH-1:0] g, input logic d);
        logic [WIDTH-1:0] b;
        b = g;
        for (int unsigned k = 1; k < WIDTH; k++)
            b = b ^ (g >> k);
        b = d ? b + WIDTH'(1) : b - WIDTH'(1);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] next_state(input logic [1:0] m, input logic d,
                                                    input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] n;
        case (m)
            MODE_BIN:  n = d ? v + WIDTH'(1) : v - WIDTH'(1);
            MODE_JOHN: n = d ? {v[WIDTH-2:0], ~v[WIDTH-1]} : {~v[0], v[WIDTH-1:1]};
            MODE_GRAY: n = gray_step(v, d);
            default:   n = d ? {v[WIDTH-2:0], v[WIDTH-1]} : {v[0], v[WIDTH-1:1]};
        endcase
        return n;
    endfunction

    logic [1:0]       prev_mode;
    logic [WIDTH-1:0] count_d;
    logic             wrap_d;
    logic             err_d;

    assign tc = (count == terminal(mode, dir));

    // Next-state selection in priority order: load, mode change, step.
    always_comb begin
        count_d = count;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        if (load) begin
            if (is_legal(mode, load_val)) begin
                count_d = load_val;
            end else begin
                count_d = origin(mode);
                err_d   = 1'b1;
            end
        end else if (mode != prev_mode) begin
            count_d = origin(mode);
        end else if (en) begin
            if (tc) begin
                if (!sat) begin
                    count_d = next_state(mode, dir, count);
                    wrap_d  = 1'b1;
                end
            end else if (!is_legal(mode, count)) begin
                count_d = origin(mode);
            end else begin
                count_d = next_state(mode, dir, count);
            end
        end
    end

    always_ff @(posedge clk) begin
        prev_mode <= mode;
        if (!rst) begin
            count <= origin(mode);
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            count <= count_d;
            wrap  <= wrap_d;
            err   <= err_d;
        end
    end

endmodule

// File: tb/tb_multimode_counter.sv
// Bench for multimode_counter: sequence-table model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_multimode_counter;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic         dir;
    logic         sat;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         tc;
    logic         wrap;
    logic         err;

    int checks = 0;
    int errors = 0;

    multimode_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .sat      (sat),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each mode is a table of states in up order, index 0 = origin.
    function automatic int seq_len(input logic [1:0] m);
        int n;
        case (m)
            2'b01:   n = 2 * int'(W);
            2'b11:   n = int'(W);
            default: n = 1 << W;
        endcase
        return n;
    endfunction

    function automatic logic [W-1:0] seq_at(input logic [1:0] m, input int i);
        logic [W-1:0] ones;
        logic [W-1:0] v;
        ones = '1;
        case (m)
            2'b00: v = W'(i);
            2'b10: v = W'(i ^ (i >> 1));
            2'b01: v = (i <= int'(W)) ? W'((1 << i) - 1) : (ones << (i - int'(W)));
            default: v = W'(1 << i);
        endcase
        return v;
    endfunction

    function automatic int seq_idx(input logic [1:0] m, input logic [W-1:0] v);
        int idx;
        idx = -1;
        for (int i = 0; i < seq_len(m); i++)
            if (idx < 0 && seq_at(m, i) == v) idx = i;
        return idx;
    endfunction

    function automatic logic [W+1:0] mdl_next(input logic [W-1:0] c, input logic [1:0] pm,
                                              input logic r, input logic ld,
                                              input logic [W-1:0] lv, input logic [1:0] md,
                                              input logic e, input logic d, input logic s);
        logic [W-1:0] nc;
        logic         nw;
        logic         ne;
        int           idx;
        int           n;
        nc = c;
        nw = 1'b0;
        ne = 1'b0;
        n  = seq_len(md);
        if (!r) begin
            nc = seq_at(md, 0);
        end else if (ld) begin
            if (seq_idx(md, lv) >= 0) nc = lv;
            else begin
                nc = seq_at(md, 0);
                ne = 1'b1;
            end
        end else if (md != pm) begin
            nc = seq_at(md, 0);
        end else if (e) begin
            idx = seq_idx(md, c);
            if (idx < 0) nc = seq_at(md, 0);
            else if (idx == (d ? n - 1 : 0)) begin
                if (!s) begin
                    nc = seq_at(md, d ? 0 : n - 1);
                    nw = 1'b1;
                end
            end else begin
                nc = seq_at(md, d ? idx + 1 : idx - 1);
            end
        end
        return {nc, nw, ne};
    endfunction

    logic [W-1:0] m_count;
    logic [1:0]   m_prev;
    logic         m_wrap;
    logic         m_err;
    logic         m_valid = 1'b0;

    always @(posedge clk) begin
        {m_count, m_wrap, m_err} <= mdl_next(m_count, m_prev, rst, load, load_val,
                                             mode, en, dir, sat);
        m_prev <= mode;
        if (!rst) m_valid <= 1'b1;
    end

    // Compare process: every cycle once the model has seen a reset edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_count", 32'(count), 32'(m_count));
            chk("model_wrap", 32'(wrap), 32'(m_wrap));
            chk("model_err", 32'(err), 32'(m_err));
            chk("model_tc", 32'(tc),
                32'(seq_idx(mode, m_count) == (dir ? seq_len(mode) - 1 : 0)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] jd [10];
    logic [W-1:0] gu [16];
    int           e;

    initial begin
        jd = '{4'h0, 4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0, 4'h8};
        gu = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
               4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        rst = 1'b0; en = 1'b0; mode = 2'b00; dir = 1'b0; sat = 1'b0;
        load = 1'b0; load_val = '0;

        tick();
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_tc", 32'(tc), 32'h1);

        // Binary down, wrapping.
        rst = 1'b1; en = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            e = (16 - k) & 15;
            chk("bin_down_count", 32'(count), 32'(e));
            chk("bin_down_wrap", 32'(wrap), 32'(e == 15));
            chk("bin_down_tc", 32'(tc), 32'(e == 0));
        end

        // Johnson down; first edge is the mode switch to origin.
        mode = 2'b01;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("john_down_count", 32'(count), 32'(jd[i]));
            chk("john_down_wrap", 32'(wrap), 32'(i > 0 && jd[i] == 4'h8));
        end

        // Gray up, saturating, then reverse.
        mode = 2'b10; dir = 1'b1; sat = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            chk("gray_up_count", 32'(count), 32'(gu[i]));
            chk("gray_up_wrap", 32'(wrap), 32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gray_sat_count", 32'(count), 32'h8);
            chk("gray_sat_tc", 32'(tc), 32'h1);
            chk("gray_sat_wrap", 32'(wrap), 32'h0);
        end
        dir = 1'b0;
        #1;
        chk("gray_dir_tc", 32'(tc), 32'h0);
        tick();
        chk("gray_rev_count", 32'(count), 32'h9);

        // Ring with load legality.
        mode = 2'b11; sat = 1'b0; en = 1'b0;
        tick();
        chk("ring_origin", 32'(count), 32'h1);
        load = 1'b1; load_val = 4'b0110;
        tick();
        chk("ring_bad_load_count", 32'(count), 32'h1);
        chk("ring_bad_load_err", 32'(err), 32'h1);
        load_val = 4'b0100; en = 1'b1;
        tick();
        chk("ring_load_count", 32'(count), 32'h4);
        chk("ring_load_err", 32'(err), 32'h0);
        load = 1'b0;
        tick();
        chk("ring_step1", 32'(count), 32'h2);
        tick();
        chk("ring_step2", 32'(count), 32'h1);
        chk("ring_tc", 32'(tc), 32'h1);
        tick();
        chk("ring_wrap_count", 32'(count), 32'h8);
        chk("ring_wrap", 32'(wrap), 32'h1);
        tick();
        chk("ring_after_wrap", 32'(count), 32'h4);
        chk("ring_wrap_clear", 32'(wrap), 32'h0);

        // Mode switch mid-count.
        mode = 2'b00; en = 1'b0;
        tick();
        chk("sw_bin_origin", 32'(count), 32'h0);
        load = 1'b1; load_val = 4'h5;
        tick();
        chk("sw_load5", 32'(count), 32'h5);
        load = 1'b0; mode = 2'b01; en = 1'b1; dir = 1'b0;
        tick();
        chk("sw_john_origin", 32'(count), 32'h0);
        tick();
        chk("sw_john_step", 32'(count), 32'h8);

        // Same-edge priority.
        rst = 1'b0; load = 1'b1; load_val = 4'b0011;
        tick();
        chk("prio_rst_count", 32'(count), 32'h0);
        chk("prio_rst_err", 32'(err), 32'h0);
        rst = 1'b1;
        tick();
        chk("prio_load_count", 32'(count), 32'h3);
        chk("prio_load_err", 32'(err), 32'h0);
        load_val = 4'b0101;
        tick();
        chk("prio_bad_count", 32'(count), 32'h0);
        chk("prio_bad_err", 32'(err), 32'h1);
        mode = 2'b11; load_val = 4'b0010;
        tick();
        chk("prio_load_mode", 32'(count), 32'h2);
        chk("prio_load_mode_err", 32'(err), 32'h0);

        // Johnson up wrap from 1000.
        mode = 2'b01; dir = 1'b1; load_val = 4'b1000;
        tick();
        chk("john_up_load", 32'(count), 32'h8);
        load = 1'b0;
        #1;
        chk("john_up_tc", 32'(tc), 32'h1);
        tick();
        chk("john_up_wrap_count", 32'(count), 32'h0);
        chk("john_up_wrap", 32'(wrap), 32'h1);
        tick();
        chk("john_up_step", 32'(count), 32'h1);
        chk("john_up_wrap_clear", 32'(wrap), 32'h0);

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
